// File: rtl/accum_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_array_pkg
// Description : Shared defaults, entry layout and clear-sweep state encoding
//               for the accumulator array.
// Options     : ACCUM_ARRAY_SATURATE_EN (used by accum_array_core)
// Revision    : 1.0 - initial release
// ============================================================================
package accum_array_pkg;

  localparam int ADDR_BITS_DEF = 10;
  localparam int KEY_W_DEF     = 32;
  localparam int CNT_W_DEF     = 32;

  // One array entry: key in the upper half, running count in the lower half.
  typedef struct packed {
    logic [KEY_W_DEF-1:0] key;
    logic [CNT_W_DEF-1:0] count;
  } entry_t;

  // Clear-sweep controller states.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/accum_array_ram.sv
`default_nettype none
// ============================================================================
// Module      : accum_array_ram
// Description : Simple dual-port RAM, one write port and one synchronous read
//               port, zero-initialised. Reset only clears the read register.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_array_ram
  import accum_array_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_W    = KEY_W_DEF + CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_W-1:0]    rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  // Storage write; kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read; returns pre-write data on a same-edge collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= '0;
    end else begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/accum_array_core.sv
`default_nettype none
// ============================================================================
// Module      : accum_array_core
// Description : Per-slot key/count accumulator array with a two-stage
//               accumulate pipeline (input register, read-modify-write with
//               forwarding), a latency-2 registered read path and a
//               kick-started clear sweep.
// Options     : ACCUM_ARRAY_SATURATE_EN - count saturates instead of wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module accum_array_core
  import accum_array_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_kick,
  output logic                   clear_busy,
  input  logic [31:0]            addr,
  input  logic [KEY_W+CNT_W-1:0] din,
  input  logic                   we,
  output logic [KEY_W+CNT_W-1:0] q
);

  localparam int DW = KEY_W + CNT_W;

  clr_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;

  logic                 s1_valid_q;
  logic [ADDR_BITS-1:0] s1_addr_q;
  logic [KEY_W-1:0]     s1_key_q;
  logic [CNT_W-1:0]     s1_inc_q;

  logic                 last_valid_q;
  logic [ADDR_BITS-1:0] last_addr_q;
  logic [CNT_W-1:0]     last_count_q;

  logic [ADDR_BITS-1:0] rd_addr_q;

  logic [ADDR_BITS-1:0] w_slot;
  logic                 w_accept;
  logic [DW-1:0]        w_rmw_rdata;
  logic [CNT_W-1:0]     w_base;
  logic [CNT_W:0]       w_sum;
  logic [CNT_W-1:0]     w_count_new;
  logic                 w_wr_en;
  logic [ADDR_BITS-1:0] w_wr_addr;
  logic [DW-1:0]        w_wr_data;
  logic                 unused_bits;

  assign w_slot     = addr[ADDR_BITS-1:0];
  assign clear_busy = (state_q == ST_CLEAR);
  // Writes are refused while sweeping and in the kick cycle itself.
  assign w_accept   = we && (state_q == ST_IDLE) && !clear_kick;

  // Clear sweep: next state and sweep index.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_kick) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDR_BITS{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear sweep state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Accumulate pipeline: input register, then record of the last committed write.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      last_valid_q <= 1'b0;
    end else begin
      s1_valid_q   <= w_accept;
      last_valid_q <= s1_valid_q && !clear_busy;
    end
    s1_addr_q    <= w_slot;
    s1_key_q     <= din[DW-1:CNT_W];
    s1_inc_q     <= din[CNT_W-1:0];
    last_addr_q  <= s1_addr_q;
    last_count_q <= w_count_new;
  end

  // Read-modify-write datapath; the RAM read misses the write committing on
  // the same edge, so that write's count is forwarded instead.
  always_comb begin
    w_base = w_rmw_rdata[CNT_W-1:0];
    if (last_valid_q && (last_addr_q == s1_addr_q)) begin
      w_base = last_count_q;
    end
    w_sum = {1'b0, w_base} + {1'b0, s1_inc_q};
`ifdef ACCUM_ARRAY_SATURATE_EN
    w_count_new = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
`else
    w_count_new = w_sum[CNT_W-1:0];
`endif
  end

  // Shared write port: the sweep owns it while busy.
  always_comb begin
    w_wr_en   = s1_valid_q;
    w_wr_addr = s1_addr_q;
    w_wr_data = {s1_key_q, w_count_new};
    if (clear_busy) begin
      w_wr_en   = 1'b1;
      w_wr_addr = clr_cnt_q;
      w_wr_data = '0;
    end
  end

  // Read path address register; RAM read follows on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
    end else begin
      rd_addr_q <= w_slot;
    end
  end

  assign unused_bits = ^{addr[31:ADDR_BITS], w_rmw_rdata[DW-1:CNT_W], w_sum[CNT_W]};

  // Copy serving the accumulate read, addressed straight from the input.
  accum_array_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DW)
  ) u_ram_rmw (
    .clk       (clk),
    .rst       (reset),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (w_wr_addr),
    .wr_data_i (w_wr_data),
    .rd_addr_i (w_slot),
    .rd_data_o (w_rmw_rdata)
  );

  // Copy serving the consumer read path.
  accum_array_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DW)
  ) u_ram_rd (
    .clk       (clk),
    .rst       (reset),
    .wr_en_i   (w_wr_en),
    .wr_addr_i (w_wr_addr),
    .wr_data_i (w_wr_data),
    .rd_addr_i (rd_addr_q),
    .rd_data_o (q)
  );

endmodule
`default_nettype wire

// File: tb/tb_accum_array_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_array_core
// Description : Self-checking bench for accum_array_core (table-driven writes
//               and reads, read-result scoreboard, clear-sweep sequences).
// Options     : ACCUM_ARRAY_SATURATE_EN selects saturating expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_array_core;
  import accum_array_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear_kick = 1'b0;
  logic        clear_busy;
  logic [31:0] addr = '0;
  logic [63:0] din = '0;
  logic        we = 1'b0;
  logic [63:0] q;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic [63:0] exp;
    string       name;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [31:0] a;
    logic [63:0] d;
  } wvec_t;

  typedef struct {
    logic [31:0] a;
    logic [63:0] exp;
  } rvec_t;

  wvec_t wtab[13];
  rvec_t rtab[4];

  accum_array_core dut (
    .clk        (clk),
    .reset      (reset),
    .clear_kick (clear_kick),
    .clear_busy (clear_busy),
    .addr       (addr),
    .din        (din),
    .we         (we),
    .q          (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and retire any scoreboard entries due now.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check(e.name, q, e.exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [63:0] d);
    we = 1'b1;
    addr = a;
    din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] exp, input string name);
    sb_t e;
    addr = a;
    e.due = cyc + 2;
    e.exp = exp;
    e.name = name;
    sbq.push_back(e);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Measure how many sampled cycles clear_busy stays high, with an
  // optional late write burst and re-kick injected during the sweep.
  task automatic sweep(input bit disturb, output int dur);
    dur = 0;
    while (clear_busy && dur < 2 * DEPTH) begin
      dur++;
      if (disturb && dur >= 20 && dur < 26) begin
        we = 1'b1;
        addr = 32'(dur % 4);
        din = {32'h11112222, 32'h5};
      end else begin
        we = 1'b0;
      end
      clear_kick = (disturb && dur == 30);
      tick();
    end
    we = 1'b0;
    clear_kick = 1'b0;
  endtask

  initial begin : main
    int          dur;
    entry_t      e;
    logic [31:0] sat_cnt;

    wtab[0]  = '{32'd0, {32'hDEADBEEF, 32'd1}};
    wtab[1]  = '{32'd0, {32'hDEADBEEF, 32'd1}};
    wtab[2]  = '{32'd0, {32'hDEADBEEF, 32'd1}};
    wtab[3]  = '{32'd1, {32'hABADCAFE, 32'd1}};
    wtab[4]  = '{32'd1, {32'hABADCAFE, 32'd1}};
    wtab[5]  = '{32'd2, {32'hFEFEFEFE, 32'd1}};
    wtab[6]  = '{32'd0, {32'hDEADBEEF, 32'd1}};
    wtab[7]  = '{32'd3, {32'h34343434, 32'd1}};
    wtab[8]  = '{32'd0, {32'hDEADBEEF, 32'd1}};
    wtab[9]  = '{32'd1, {32'hABADCAFE, 32'd1}};
    wtab[10] = '{32'd0, {32'hDEADBEEF, 32'd1}};
    wtab[11] = '{32'd3, {32'h34343434, 32'd1}};
    wtab[12] = '{32'd0, {32'hDEADBEEF, 32'd1}};
    rtab[0]  = '{32'd0, {32'hDEADBEEF, 32'd7}};
    rtab[1]  = '{32'd1, {32'hABADCAFE, 32'd3}};
    rtab[2]  = '{32'd2, {32'hFEFEFEFE, 32'd1}};
    rtab[3]  = '{32'd3, {32'h34343434, 32'd2}};

    // 1: reset, then reads of an untouched array
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    check("reset_busy", {63'd0, clear_busy}, 64'd0);
    check("reset_q", q, 64'd0);
    for (int i = 0; i < 4; i++) rd(32'(i), 64'd0, "init_read");
    drain();

    // 2: accumulate stream with same-slot back-to-back writes
    for (int i = 0; i < 13; i++) wr(wtab[i].a, wtab[i].d);
    for (int i = 0; i < 4; i++) rd(rtab[i].a, rtab[i].exp, "accum_read");
    drain();

    // 3: plain clear sweep
    clear_kick = 1'b1;
    tick();
    clear_kick = 1'b0;
    check("busy_after_kick", {63'd0, clear_busy}, 64'd1);
    sweep(1'b0, dur);
    check("clear_duration", 64'(dur), 64'(DEPTH));
    for (int i = 0; i < 4; i++) rd(32'(i), 64'd0, "cleared_read");
    drain();

    // 4: wrap or saturate on overflow, through the forwarding path
`ifdef ACCUM_ARRAY_SATURATE_EN
    sat_cnt = 32'hFFFFFFFF;
`else
    sat_cnt = 32'd1;
`endif
    wr(32'd5, {32'h0000AAAA, 32'hFFFFFFFF});
    wr(32'd5, {32'h0000BBBB, 32'd2});
    tick();
    tick();
    e.key = 32'h0000BBBB;
    e.count = sat_cnt;
    rd(32'd5, e, "overflow_read");
    drain();

    // 5a: writes and re-kick during a sweep, plus a write in the kick cycle
    clear_kick = 1'b1;
    we = 1'b1;
    addr = 32'd7;
    din = {32'h77777777, 32'd9};
    tick();
    clear_kick = 1'b0;
    we = 1'b0;
    sweep(1'b1, dur);
    check("disturbed_duration", 64'(dur), 64'(DEPTH));
    for (int i = 0; i < 8; i++) rd(32'(i), 64'd0, "disturbed_read");
    drain();

    // 5b: reset mid-sweep keeps not-yet-cleared contents
    wr(32'd9, {32'h99999999, 32'd42});
    tick();
    tick();
    clear_kick = 1'b1;
    tick();
    clear_kick = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("busy_after_reset", {63'd0, clear_busy}, 64'd0);
    check("q_after_reset", q, 64'd0);
    tick();
    check("busy_stays_low", {63'd0, clear_busy}, 64'd0);
    rd(32'd9, {32'h99999999, 32'd42}, "kept_read");
    rd(32'd1, 64'd0, "partial_cleared_read");
    drain();

    // 6: upper address bits are ignored
    wr(32'h000003FF, {32'hCAFEF00D, 32'h00001234});
    tick();
    tick();
    rd(32'hFFFFFFFF, {32'hCAFEF00D, 32'h00001234}, "wrap_read");
    drain();

    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
